// File: rtl/encoder_if.sv
// ============================================================================
// Module  : encoder_if
// Brief   : Keypad-side and load-side signals of the keypad encoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface encoder_if;
    logic [9:0] key;
    logic       enablen;
    logic [3:0] d;
    logic       loadn;
    logic       valid;

    // master drives the keypad and consumes the code; slave is the encoder
    modport master (
        output key,
        output enablen,
        input  d,
        input  loadn,
        input  valid
    );

    modport slave (
        input  key,
        input  enablen,
        output d,
        output loadn,
        output valid
    );
endinterface

`default_nettype wire

// File: rtl/encoder.sv
// ============================================================================
// Module  : encoder
// Brief   : Debounced one-hot keypad to BCD encoder with one-cycle load strobe.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module encoder #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic     clk,
    input  logic     resetn,
    encoder_if.slave kp
);

    localparam logic [1:0] C_IDLE         = 2'd0;
    localparam logic [1:0] C_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] C_PRESSED      = 2'd2;
    localparam logic [1:0] C_RELEASE_WAIT = 2'd3;

    localparam logic [3:0] C_DEBOUNCE = 4'(DEBOUNCE_CYCLES);

    logic [9:0] key_meta_q;
    logic [9:0] key_sync_q;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] cand_q,  cand_d;
    logic [3:0] d_q,     d_d;
    logic       loadn_q, loadn_d;
    logic       valid_q, valid_d;

    logic [3:0] w_code;
    logic       w_any;
    logic [3:0] w_cnt_inc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
        end else begin
            key_meta_q <= kp.key;
            key_sync_q <= key_meta_q;
        end
    end

    // Ascending scan so the highest pressed index overrides lower ones
    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_sync_q[i]) begin
                w_code = 4'(i);
            end
        end
    end

    assign w_any     = |key_sync_q;
    assign w_cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        d_d     = d_q;
        loadn_d = 1'b1;

        if (kp.enablen) begin
            state_d = C_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (w_any) begin
                        cand_d = w_code;
                        if (C_DEBOUNCE == 4'd1) begin
                            d_d     = w_code;
                            loadn_d = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = C_PRESSED;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = C_PRESS_WAIT;
                        end
                    end
                end

                C_PRESS_WAIT: begin
                    if (!w_any) begin
                        cnt_d   = 4'd0;
                        state_d = C_IDLE;
                    end else if (w_code != cand_q) begin
                        // A different key restarts the stability window
                        cand_d = w_code;
                        cnt_d  = 4'd1;
                    end else if (w_cnt_inc >= C_DEBOUNCE) begin
                        d_d     = cand_q;
                        loadn_d = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = C_PRESSED;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end

                C_PRESSED: begin
                    if (!w_any) begin
                        if (C_DEBOUNCE == 4'd1) begin
                            cnt_d   = 4'd0;
                            state_d = C_IDLE;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = C_RELEASE_WAIT;
                        end
                    end
                end

                C_RELEASE_WAIT: begin
                    if (w_any) begin
                        cnt_d   = 4'd0;
                        state_d = C_PRESSED;
                    end else if (w_cnt_inc >= C_DEBOUNCE) begin
                        cnt_d   = 4'd0;
                        state_d = C_IDLE;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end

                default: begin
                    cnt_d   = 4'd0;
                    state_d = C_IDLE;
                end
            endcase
        end

        valid_d = (state_d == C_PRESSED) || (state_d == C_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= C_IDLE;
            cnt_q   <= 4'd0;
            cand_q  <= 4'd0;
            d_q     <= 4'd0;
            loadn_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            loadn_q <= loadn_d;
            valid_q <= valid_d;
        end
    end

    assign kp.d     = d_q;
    assign kp.loadn = loadn_q;
    assign kp.valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder.sv
// ============================================================================
// Module  : tb_encoder
// Brief   : Directed self-checking bench for the keypad encoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_encoder;

    logic clk;
    logic resetn;

    encoder_if kp_if ();

    encoder #(
        .DEBOUNCE_CYCLES(2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .kp     (kp_if)
    );

    int total = 0;
    int bad   = 0;

    int         pulses  = 0;
    logic [3:0] pulse_d = 4'd0;
    logic       prev_loadn = 1'b1;
    int         base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 units after a rising edge, well clear of sampling
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Strobe monitor: counts pulses and guards the output invariants
    always @(negedge clk) begin
        if (resetn && kp_if.loadn === 1'b0) begin
            pulses++;
            pulse_d = kp_if.d;
            check("loadn_single_cycle", {31'd0, prev_loadn}, 32'd1);
            check("d_is_bcd", {31'd0, (kp_if.d <= 4'd9)}, 32'd1);
        end
        prev_loadn = resetn ? kp_if.loadn : 1'b1;
    end

    initial begin
        resetn        = 1'b0;
        kp_if.key     = 10'b0000000100;
        kp_if.enablen = 1'b0;

        // Reset held with key[2] pressed
        step(3);
        check("rst_d",     {28'd0, kp_if.d}, 32'd0);
        check("rst_loadn", {31'd0, kp_if.loadn}, 32'd1);
        check("rst_valid", {31'd0, kp_if.valid}, 32'd0);

        // Release reset with the key held: strobe after exactly 4 edges
        resetn = 1'b1;
        step(4);
        @(negedge clk);
        check("rel_rst_loadn_low", {31'd0, kp_if.loadn}, 32'd0);
        check("rel_rst_d",         {28'd0, kp_if.d}, 32'd2);
        check("rel_rst_valid",     {31'd0, kp_if.valid}, 32'd1);
        @(negedge clk);
        check("rel_rst_loadn_high", {31'd0, kp_if.loadn}, 32'd1);
        step(10);
        kp_if.key = '0;
        step(8);
        check("rel_rst_pulses",  pulses, 32'd1);
        check("rel_rst_valid_0", {31'd0, kp_if.valid}, 32'd0);

        // Clean press of key[0]
        base = pulses;
        kp_if.key = 10'b0000000001;
        step(20);
        check("clean_pulses", pulses - base, 32'd1);
        check("clean_d",      {28'd0, kp_if.d}, 32'd0);
        check("clean_pd",     {28'd0, pulse_d}, 32'd0);
        check("clean_valid",  {31'd0, kp_if.valid}, 32'd1);
        kp_if.key = '0;
        step(8);
        check("clean_valid_rel", {31'd0, kp_if.valid}, 32'd0);

        // Bouncing contact then a steady hold
        base = pulses;
        kp_if.key = 10'b0000000001; #1;
        kp_if.key = 10'b0000000000; #3;
        kp_if.key = 10'b0000000001; #5;
        kp_if.key = 10'b0000000000; #2;
        kp_if.key = 10'b0000000001; #8;
        kp_if.key = 10'b0000000000; #1;
        kp_if.key = 10'b0000000001;
        step(12);
        check("bounce_pulses", pulses - base, 32'd1);
        check("bounce_pd",     {28'd0, pulse_d}, 32'd0);
        kp_if.key = '0;
        step(8);

        // Press shorter than the debounce window
        base = pulses;
        kp_if.key = 10'b0000001000;
        step(1);
        kp_if.key = '0;
        step(8);
        check("short_pulses", pulses - base, 32'd0);
        check("short_d",      {28'd0, kp_if.d}, 32'd0);
        check("short_valid",  {31'd0, kp_if.valid}, 32'd0);

        // Priority, then key change while held
        base = pulses;
        kp_if.key = 10'b1000010000;
        step(8);
        check("prio_pulses", pulses - base, 32'd1);
        check("prio_d",      {28'd0, kp_if.d}, 32'd9);
        kp_if.key = 10'b0000010000;
        step(8);
        check("change_pulses", pulses - base, 32'd1);
        check("change_d",      {28'd0, kp_if.d}, 32'd9);
        check("change_valid",  {31'd0, kp_if.valid}, 32'd1);
        kp_if.key = '0;
        step(8);
        kp_if.key = 10'b0000010000;
        step(8);
        check("key4_pulses", pulses - base, 32'd2);
        check("key4_d",      {28'd0, kp_if.d}, 32'd4);
        kp_if.key = '0;
        step(8);

        // Disabled keypad ignores key[7], enabling debounces it as new
        base = pulses;
        kp_if.enablen = 1'b1;
        kp_if.key     = 10'b0010000000;
        step(10);
        check("dis_pulses", pulses - base, 32'd0);
        check("dis_valid",  {31'd0, kp_if.valid}, 32'd0);
        check("dis_loadn",  {31'd0, kp_if.loadn}, 32'd1);
        check("dis_d",      {28'd0, kp_if.d}, 32'd4);
        kp_if.enablen = 1'b0;
        step(8);
        check("en_pulses", pulses - base, 32'd1);
        check("en_d",      {28'd0, kp_if.d}, 32'd7);
        check("en_valid",  {31'd0, kp_if.valid}, 32'd1);
        kp_if.key = '0;
        step(8);

        // Reset asserted while the FSM is in PRESS_WAIT
        base = pulses;
        kp_if.key = 10'b0000100000;
        step(3);
        resetn = 1'b0;
        #1;
        check("midrst_d",     {28'd0, kp_if.d}, 32'd0);
        check("midrst_loadn", {31'd0, kp_if.loadn}, 32'd1);
        check("midrst_valid", {31'd0, kp_if.valid}, 32'd0);
        kp_if.key = '0;
        step(3);
        resetn = 1'b1;
        step(8);
        check("midrst_pulses", pulses - base, 32'd0);
        check("midrst_d_after", {28'd0, kp_if.d}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/encoder.md
Name: encoder

Overview:
- Keypad encoder for the microwave controller front end.
- Converts a 10-line one-hot digit keypad (keys 0–9) into a registered 4-bit BCD code plus a one-clock active-low load strobe.
- Debounces presses and releases so that bouncing contacts produce exactly one strobe per press.
- Sits between the raw keypad and the time-entry register; the register captures `d` while `loadn` is low.

Parameters:
- DEBOUNCE_CYCLES, 2, consecutive clock samples a press or release must stay stable before it is accepted (legal range 1–15).

Ports:
- clk  in  1  system clock; all state updates on rising edge (nominal 100 Hz).
- resetn  in  1  asynchronous active-low reset.
- key  in  10  raw keypad; key[i]=1 means digit i pressed; asynchronous to clk.
- enablen  in  1  active-low enable; 1 = keypad ignored.
- d  out  4  BCD code of the last accepted digit (0–9).
- loadn  out  1  active-low strobe; low for exactly one clk cycle per accepted press.
- valid  out  1  high while an accepted key is held (PRESSED or RELEASE_WAIT states).

Behaviour:
- Synchronizer: `key` passes through a 2-flop synchronizer before any decoding. Glitches shorter than one clk period that are not present at a rising edge are never seen.
- Priority encode of the synchronized key:
  - The highest set index wins (key=10'b1000000011 encodes 9).
  - `any` = OR of all synchronized keys.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - If any=1, latch the encoded code into `cand`, set cnt=1, go to PRESS_WAIT.
  - If DEBOUNCE_CYCLES=1, go directly to PRESSED and strobe.
- PRESS_WAIT:
  - any=0: return to IDLE.
  - Encoded code differs from cand: reload cand, cnt=1.
  - Otherwise cnt++.
  - When cnt reaches DEBOUNCE_CYCLES: d<=cand, loadn<=0 for the next cycle only, go to PRESSED.
- PRESSED:
  - loadn returns to 1 after one cycle.
  - A change to a different key while held is ignored; no new strobe.
  - any=0: cnt=1, go to RELEASE_WAIT.
- RELEASE_WAIT:
  - any=1: back to PRESSED, without a strobe.
  - any=0 for DEBOUNCE_CYCLES consecutive samples: go to IDLE.
- enablen=1 (sampled synchronously):
  - FSM forced to IDLE and counters cleared.
  - loadn held at 1, valid=0; d holds its last value.
  - A key already held when enablen falls to 0 is treated as a new press and is debounced normally.
- Reset (resetn=0, asynchronous, at any time including mid-debounce):
  - FSM=IDLE, d=4'd0, loadn=1, valid=0, cnt=0, cand=0, synchronizer flops=0.
- Latency: from key stable at a rising edge to loadn low is 2 (synchronizer) + DEBOUNCE_CYCLES clk edges. With the default this is 4 edges, ±1 edge for input-to-edge alignment.
- All outputs are registered; no combinational path from key to any output.
- Invariants:
  - d never takes a value above 9.
  - loadn is never low for two consecutive cycles.

Test Plan:
- Reset: hold resetn=0 with key=10'b0000000100 → d=0, loadn=1, valid=0. Release reset while holding the key → exactly one loadn pulse with d=2 after 4 edges.
- Clean press: key=10'b0000000001 held for 20 clk cycles, then released → exactly one 1-cycle loadn pulse, d=0, valid=1 until release is debounced, then 0.
- Bounce: key toggles 1/0 at sub-period intervals (1 ms, 3 ms, 5 ms, 2 ms, 8 ms) with clk period 10 ms, then is held → exactly one loadn pulse, d=0. A press shorter than DEBOUNCE_CYCLES samples → no pulse.
- Priority and key change: key=10'b1000010000 → d=9. While still held, change to 10'b0000010000 → no new pulse, d stays 9. Release fully, then press key[4] → pulse with d=4.
- Enable: enablen=1 with key[7] pressed → loadn stays 1, valid=0, d unchanged. Drop enablen to 0 with key[7] still held → one pulse with d=7.
- Mid-debounce reset: assert resetn=0 during PRESS_WAIT → no pulse, all outputs at reset values immediately, without waiting for a clk edge.
